// File: rtl/tnn_batch_scheduler.sv
// Batch sequencer for a sequential TNN classifier: fetches each sample, clears the
// engine, waits out its compute latency, and streams predictions with a running score.
module tnn_batch_scheduler #(
  parameter int FEAT_CNT       = 11,
  parameter int FEAT_BITS      = 4,
  parameter int CLASS_CNT      = 6,
  parameter int TEST_CNT       = 1000,
  parameter int COMPUTE_CYCLES = 42,
  localparam int FW  = FEAT_CNT * FEAT_BITS,
  localparam int PW  = $clog2(CLASS_CNT),
  localparam int IW  = $clog2(TEST_CNT),
  localparam int CW  = $clog2(TEST_CNT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          sample_rd,
  output logic [IW-1:0] sample_addr,
  input  logic [FW-1:0] sample_data,
  input  logic [PW-1:0] sample_label,
  output logic          tnn_clear,
  output logic [FW-1:0] tnn_features,
  input  logic [PW-1:0] tnn_prediction,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [IW-1:0] res_index,
  output logic [PW-1:0] res_pred,
  output logic          res_correct,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] correct_cnt,
  output logic [2:0]    state_dbg
);

  localparam int YW = $clog2(COMPUTE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_LOAD    = 3'd2,
    S_COMPUTE = 3'd3,
    S_EMIT    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx;
  logic [PW-1:0]   label_q;
  logic [YW-1:0]   cyc;
  logic            last_idx;
  logic            res_fire;

  // Result stream: a transfer happens on a rising edge where res_valid && res_ready.
  // res_valid only falls after a transfer and the payload is frozen while it is high.
  assign res_fire  = res_valid && res_ready;
  assign last_idx  = (idx == IW'(TEST_CNT - 1));

  assign sample_rd   = (state == S_FETCH);
  assign sample_addr = idx;
  assign tnn_clear   = (state == S_LOAD);
  assign res_valid   = (state == S_EMIT);
  assign done        = (state == S_DONE);
  assign busy        = (state != S_IDLE) && (state != S_DONE);
  assign state_dbg   = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_FETCH;
      S_FETCH:   state_nxt = S_LOAD;
      S_LOAD:    state_nxt = S_COMPUTE;
      S_COMPUTE: if (cyc == '0) state_nxt = S_EMIT;
      S_EMIT:    if (res_fire) state_nxt = last_idx ? S_DONE : S_FETCH;
      S_DONE:    if (start) state_nxt = S_FETCH;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx          <= '0;
      label_q      <= '0;
      cyc          <= '0;
      tnn_features <= '0;
      res_index    <= '0;
      res_pred     <= '0;
      res_correct  <= 1'b0;
      correct_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            idx         <= '0;
            correct_cnt <= '0;
          end
        end
        S_LOAD: begin
          // Memory data arrives this cycle; the engine clear lands on the same edge.
          tnn_features <= sample_data;
          label_q      <= sample_label;
          cyc          <= YW'(COMPUTE_CYCLES - 1);
        end
        S_COMPUTE: begin
          if (cyc == '0) begin
            res_pred    <= tnn_prediction;
            res_correct <= (tnn_prediction == label_q);
            res_index   <= idx;
          end else begin
            cyc <= cyc - 1'b1;
          end
        end
        S_EMIT: begin
          if (res_fire) begin
            correct_cnt <= correct_cnt + CW'(res_correct);
            if (!last_idx) idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tnn_batch_scheduler.sv
// Directed bench for tnn_batch_scheduler: small batch with a memory model and an
// engine model whose prediction is only valid exactly COMPUTE_CYCLES after clear.
module tb_tnn_batch_scheduler;

  localparam int C  = 42;
  localparam int N  = 4;
  localparam int FW = 44;
  localparam int PW = 3;
  localparam int IW = 2;
  localparam int CW = 3;

  logic          clk;
  logic          rst;
  logic          start;
  logic          sample_rd;
  logic [IW-1:0] sample_addr;
  logic [FW-1:0] sample_data;
  logic [PW-1:0] sample_label;
  logic          tnn_clear;
  logic [FW-1:0] tnn_features;
  logic [PW-1:0] tnn_prediction;
  logic          res_valid;
  logic          res_ready;
  logic [IW-1:0] res_index;
  logic [PW-1:0] res_pred;
  logic          res_correct;
  logic          busy;
  logic          done;
  logic [CW-1:0] correct_cnt;
  logic [2:0]    state_dbg;

  tnn_batch_scheduler #(
    .FEAT_CNT(11), .FEAT_BITS(4), .CLASS_CNT(6), .TEST_CNT(N), .COMPUTE_CYCLES(C)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .sample_rd(sample_rd), .sample_addr(sample_addr),
    .sample_data(sample_data), .sample_label(sample_label),
    .tnn_clear(tnn_clear), .tnn_features(tnn_features), .tnn_prediction(tnn_prediction),
    .res_valid(res_valid), .res_ready(res_ready), .res_index(res_index),
    .res_pred(res_pred), .res_correct(res_correct),
    .busy(busy), .done(done), .correct_cnt(correct_cnt), .state_dbg(state_dbg)
  );

  typedef struct {
    logic [FW-1:0] feat;
    logic [PW-1:0] label;
    logic [PW-1:0] pred;
    logic          exp_correct;
  } vec_t;

  vec_t vec[N];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   edge_cnt = 0;
  logic [7:0] eng_cnt = 8'hff;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // sample memory: data valid only in the cycle after a read strobe
  always @(posedge clk) begin
    if (sample_rd) begin
      sample_data  <= vec[sample_addr].feat;
      sample_label <= vec[sample_addr].label;
    end else begin
      sample_data  <= '1;
      sample_label <= 3'd7;
    end
  end

  // engine: counts from clear; prediction is meaningful only at count C-1
  always @(posedge clk) begin
    if (tnn_clear)              eng_cnt <= 8'd0;
    else if (eng_cnt != 8'hff)  eng_cnt <= eng_cnt + 8'd1;
  end

  function automatic logic [PW-1:0] pred_of(input logic [FW-1:0] f);
    for (int j = 0; j < N; j++)
      if (vec[j].feat == f) return vec[j].pred;
    return 3'd7;
  endfunction

  assign tnn_prediction = (eng_cnt == 8'(C - 1)) ? pred_of(tnn_features) : 3'd7;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_valid(input int max_cyc);
    int k;
    k = 0;
    while (!res_valid && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    if (!res_valid) check("res_valid_timeout", {63'd0, res_valid}, 64'd1);
  endtask

  // start issued at negedge; returns the edge index at which start was sampled
  task automatic do_start(output int t0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = edge_cnt;
    check("start_sample_rd", {63'd0, sample_rd}, 64'd1);
    check("start_addr", {62'd0, sample_addr}, 64'd0);
    check("start_cnt_cleared", {61'd0, correct_cnt}, 64'd0);
    check("start_done_low", {63'd0, done}, 64'd0);
  endtask

  task automatic run_batch(input int t0, input int n_samples, input int stall_idx, input int pulse_idx);
    int last_edge;
    int exp_cnt;
    logic [IW-1:0] hold_idx;
    logic [PW-1:0] hold_pred;
    last_edge = t0;
    exp_cnt   = 0;
    for (int i = 0; i < n_samples; i++) begin
      if (i == pulse_idx) begin
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("pulse_busy", {63'd0, busy}, 64'd1);
        check("pulse_no_rd", {63'd0, sample_rd}, 64'd0);
      end
      if (i == stall_idx) res_ready = 1'b0;
      wait_valid(200);
      check("latency", 64'(edge_cnt - last_edge), (i == 0) ? 64'(C + 2) : 64'(C + 3));
      last_edge = edge_cnt;
      check("res_index", {62'd0, res_index}, 64'(i));
      check("res_pred", {61'd0, res_pred}, {61'd0, vec[i].pred});
      check("res_correct", {63'd0, res_correct}, {63'd0, vec[i].exp_correct});
      check("features_held", {20'd0, tnn_features}, {20'd0, vec[i].feat});
      check("cnt_before_hs", {61'd0, correct_cnt}, 64'(exp_cnt));
      if (i == stall_idx) begin
        hold_idx  = res_index;
        hold_pred = res_pred;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          check("stall_valid", {63'd0, res_valid}, 64'd1);
          check("stall_index", {62'd0, res_index}, {62'd0, hold_idx});
          check("stall_pred", {61'd0, res_pred}, {61'd0, hold_pred});
          check("stall_no_rd", {63'd0, sample_rd}, 64'd0);
        end
        last_edge = last_edge + 10;
        res_ready = 1'b1;
      end
      if (vec[i].exp_correct) exp_cnt++;
      @(negedge clk);
    end
    if (n_samples == N) begin
      check("done_level", {63'd0, done}, 64'd1);
      check("done_not_busy", {63'd0, busy}, 64'd0);
      check("done_no_valid", {63'd0, res_valid}, 64'd0);
      check("final_cnt", {61'd0, correct_cnt}, 64'(exp_cnt));
      repeat (3) @(negedge clk);
      check("done_holds", {63'd0, done}, 64'd1);
      check("final_cnt_holds", {61'd0, correct_cnt}, 64'(exp_cnt));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sample_rd"}, {63'd0, sample_rd}, 64'd0);
    check({tag, "_addr"}, {62'd0, sample_addr}, 64'd0);
    check({tag, "_clear"}, {63'd0, tnn_clear}, 64'd0);
    check({tag, "_features"}, {20'd0, tnn_features}, 64'd0);
    check({tag, "_res_valid"}, {63'd0, res_valid}, 64'd0);
    check({tag, "_res_index"}, {62'd0, res_index}, 64'd0);
    check({tag, "_res_pred"}, {61'd0, res_pred}, 64'd0);
    check({tag, "_res_correct"}, {63'd0, res_correct}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_cnt"}, {61'd0, correct_cnt}, 64'd0);
  endtask

  initial begin
    int t0;
    vec[0] = '{feat: 44'h1A2_B3C4_D5E6, label: 3'd2, pred: 3'd2, exp_correct: 1'b1};
    vec[1] = '{feat: 44'h0F1_E2D3_C4B5, label: 3'd5, pred: 3'd4, exp_correct: 1'b0};
    vec[2] = '{feat: 44'h777_0000_1234, label: 3'd0, pred: 3'd0, exp_correct: 1'b1};
    vec[3] = '{feat: 44'hABC_DEF0_1357, label: 3'd3, pred: 3'd1, exp_correct: 1'b0};

    rst       = 1'b0;
    start     = 1'b1;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    // batch 1: start held through reset is taken on the first edge after release
    rst = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = edge_cnt;
    check("rel_sample_rd", {63'd0, sample_rd}, 64'd1);
    check("rel_addr", {62'd0, sample_addr}, 64'd0);
    check("rel_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    check("load_clear", {63'd0, tnn_clear}, 64'd1);
    check("load_no_rd", {63'd0, sample_rd}, 64'd0);
    run_batch(t0, N, -1, -1);

    // batch 2: restart from DONE, stall sample 0, ignored start during COMPUTE of sample 1
    do_start(t0);
    run_batch(t0, N, 0, 1);

    // batch 3: reset in the middle of COMPUTE for sample 2
    do_start(t0);
    run_batch(t0, 2, -1, -1);
    repeat (10) @(negedge clk);
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    check("pre_rst_features", {20'd0, tnn_features}, {20'd0, vec[2].feat});
    #2 rst = 1'b0;
    #1 check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_after_rst_busy", {63'd0, busy}, 64'd0);
    check("idle_after_rst_rd", {63'd0, sample_rd}, 64'd0);
    check("idle_after_rst_done", {63'd0, done}, 64'd0);
    check("idle_after_rst_valid", {63'd0, res_valid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
